// File: rtl/page_cache.sv
// page_cache: fully associative page-tag cache controller for a 65816-style
// multiplexed bus. phi2 is synchronised into the fpga domain. The bank byte is
// latched while phi2 is low. A 24-bit address is formed on each phi2 rise,
// and its page tag is looked up across PAGES entries. A miss picks an LRU
// victim and holds a level fill request until the backing store acks.
//
// Fill handshake: fill_req rises together with the miss done pulse. fill_tag
// and fill_page stay stable while fill_req is high. The store answers with a
// single fill_ack, which is honoured only while fill_req is high. fill_req
// drops in the cycle after the ack is sampled.
module page_cache #(
  parameter int PAGES     = 4,
  parameter int PAGE_BITS = 8,
  localparam int PW       = $clog2(PAGES),
  localparam int TW       = 24 - PAGE_BITS
) (
  input  logic             fpga,
  input  logic             reset,
  input  logic [15:0]      a,
  input  logic [7:0]       d,
  input  logic             phi2,
  input  logic             flush,
  input  logic             fill_ack,
  output logic             done,
  output logic             hit,
  output logic [PW-1:0]    hit_page,
  output logic             fill_req,
  output logic [TW-1:0]    fill_tag,
  output logic [PW-1:0]    fill_page,
  output logic [PAGES-1:0] valid,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;

  logic             s1_q, s2_q, s3_q;
  logic [7:0]       bank_q, bank_d;
  logic [23:0]      addr_q, addr_d;
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tag_q [PAGES];
  logic [TW-1:0]    tag_d [PAGES];
  logic [PW-1:0]    age_q [PAGES];
  logic [PW-1:0]    age_d [PAGES];
  logic [PAGES-1:0] valid_q, valid_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic [PW-1:0]    hit_page_q, hit_page_d;
  logic             fill_req_q, fill_req_d;
  logic [TW-1:0]    fill_tag_q, fill_tag_d;
  logic [PW-1:0]    fill_page_q, fill_page_d;
  logic             overrun_q, overrun_d;

  logic             rise;
  logic [TW-1:0]    lookup_tag;
  logic             hit_found;
  logic [PW-1:0]    hit_idx;
  logic             inv_found;
  logic [PW-1:0]    victim;
  logic             touch_en;
  logic [PW-1:0]    touch_idx;
  logic             unused_offset_bits;

  assign rise       = s2_q & ~s3_q;
  assign lookup_tag = addr_q[23:PAGE_BITS];
  // Page offset bits are carried in addr_q but never take part in matching.
  assign unused_offset_bits = ^addr_q[PAGE_BITS-1:0];

  // Tag match (lowest matching valid entry) and victim choice.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    victim    = '0;
    for (int i = 0; i < PAGES; i++) begin
      if (!hit_found && valid_q[i] && (tag_q[i] == lookup_tag)) begin
        hit_found = 1'b1;
        hit_idx   = PW'(i);
      end
      if (!inv_found && !valid_q[i]) begin
        inv_found = 1'b1;
        victim    = PW'(i);
      end
    end
    if (!inv_found) begin
      for (int i = 0; i < PAGES; i++) begin
        if (age_q[i] == PW'(PAGES - 1)) victim = PW'(i);
      end
    end
  end

  // Next-state logic: FSM, fill handshake, flush, overrun and LRU ageing.
  always_comb begin
    bank_d      = s1_q ? bank_q : d;
    addr_d      = addr_q;
    state_d     = state_q;
    tag_d       = tag_q;
    age_d       = age_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    hit_d       = 1'b0;
    hit_page_d  = hit_page_q;
    fill_req_d  = fill_req_q;
    fill_tag_d  = fill_tag_q;
    fill_page_d = fill_page_q;
    overrun_d   = overrun_q;
    touch_en    = 1'b0;
    touch_idx   = '0;

    if (flush) begin
      // Flush beats any ack or rise in the same cycle.
      valid_d    = '0;
      overrun_d  = 1'b0;
      state_d    = S_IDLE;
      fill_req_d = 1'b0;
      for (int i = 0; i < PAGES; i++) age_d[i] = PW'(i);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            addr_d  = {bank_q, a};
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (rise) overrun_d = 1'b1;
          done_d = 1'b1;
          if (hit_found) begin
            hit_d      = 1'b1;
            hit_page_d = hit_idx;
            touch_en   = 1'b1;
            touch_idx  = hit_idx;
            state_d    = S_IDLE;
          end else begin
            hit_page_d  = victim;
            fill_page_d = victim;
            fill_tag_d  = lookup_tag;
            fill_req_d  = 1'b1;
            state_d     = S_FILL;
          end
        end
        S_FILL: begin
          if (rise) overrun_d = 1'b1;
          if (fill_ack && fill_req_q) begin
            tag_d[fill_page_q]   = fill_tag_q;
            valid_d[fill_page_q] = 1'b1;
            touch_en             = 1'b1;
            touch_idx            = fill_page_q;
            fill_req_d           = 1'b0;
            state_d              = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Touch: younger-than-target entries age by one, target becomes newest.
    if (touch_en) begin
      for (int i = 0; i < PAGES; i++) begin
        if (age_q[i] < age_q[touch_idx]) age_d[i] = age_q[i] + PW'(1);
      end
      age_d[touch_idx] = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge fpga) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      bank_q      <= '0;
      addr_q      <= '0;
      state_q     <= S_IDLE;
      valid_q     <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_page_q  <= '0;
      fill_req_q  <= 1'b0;
      fill_tag_q  <= '0;
      fill_page_q <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < PAGES; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= PW'(i);
      end
    end else begin
      s1_q        <= phi2;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      state_q     <= state_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      hit_page_q  <= hit_page_d;
      fill_req_q  <= fill_req_d;
      fill_tag_q  <= fill_tag_d;
      fill_page_q <= fill_page_d;
      overrun_q   <= overrun_d;
      tag_q       <= tag_d;
      age_q       <= age_d;
    end
  end

  assign done      = done_q;
  assign hit       = hit_q;
  assign hit_page  = hit_page_q;
  assign fill_req  = fill_req_q;
  assign fill_tag  = fill_tag_q;
  assign fill_page = fill_page_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
